// File: rtl/sobel_frame_ctrl_if.sv
// Handshake bundle between the Sobel frame sequencer and its environment.
// slave: the controller side. master: the source/sink/frame-RAM side.
interface sobel_frame_ctrl_if;
    logic        start;
    logic        pix_valid;
    logic        pix_ready;
    logic        wr_en;
    logic [8:0]  wr_row;
    logic [9:0]  wr_col;
    logic        rd_en;
    logic [8:0]  win_row;
    logic [9:0]  win_col;
    logic        out_ready;
    logic        out_valid;
    logic        busy;
    logic        load_done;
    logic        frame_done;
`ifdef SOBEL_FRAME_CNT_EN
    logic        abort;
    logic [15:0] frame_cnt;

    modport slave (
        input  start, pix_valid, out_ready, abort,
        output pix_ready, wr_en, wr_row, wr_col,
        output rd_en, win_row, win_col, out_valid,
        output busy, load_done, frame_done, frame_cnt
    );

    modport master (
        output start, pix_valid, out_ready, abort,
        input  pix_ready, wr_en, wr_row, wr_col,
        input  rd_en, win_row, win_col, out_valid,
        input  busy, load_done, frame_done, frame_cnt
    );
`else
    modport slave (
        input  start, pix_valid, out_ready,
        output pix_ready, wr_en, wr_row, wr_col,
        output rd_en, win_row, win_col, out_valid,
        output busy, load_done, frame_done
    );

    modport master (
        output start, pix_valid, out_ready,
        input  pix_ready, wr_en, wr_row, wr_col,
        input  rd_en, win_row, win_col, out_valid,
        input  busy, load_done, frame_done
    );
`endif
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Sobel frame sequencer: LOAD a raster frame into RAM, sweep all 3x3
// windows (PROCESS), wait for in-flight core results (DRAIN), pulse done.
// Ports: clk, reset (async, active-high), bus (sobel_frame_ctrl_if.slave):
//   start/pix_valid/out_ready in; pix_ready/wr_en/wr_row/wr_col,
//   rd_en/win_row/win_col, out_valid, busy, load_done, frame_done out.
// Optional macro SOBEL_FRAME_CNT_EN adds bus.frame_cnt and bus.abort.
module sobel_frame_ctrl #(
    parameter int RES_X    = 30,
    parameter int RES_Y    = 30,
    parameter int CORE_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    sobel_frame_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PROC,
        S_DRAIN
    } state_t;

    localparam logic [8:0] WR_ROW_LAST  = 9'(RES_Y - 1);
    localparam logic [9:0] WR_COL_LAST  = 10'(RES_X - 1);
    localparam logic [8:0] WIN_ROW_LAST = 9'(RES_Y - 3);
    localparam logic [9:0] WIN_COL_LAST = 10'(RES_X - 3);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_pix_ready;
    logic                r_load_done;
    logic                r_frame_done;
    logic [8:0]          r_wr_row;
    logic [9:0]          r_wr_col;
    logic [8:0]          r_win_row;
    logic [9:0]          r_win_col;
    logic [CORE_LAT-1:0] r_pipe;
    logic [CORE_LAT-1:0] w_pipe_nxt;
    logic                w_wr_en;
    logic                w_rd_en;
    logic                w_wr_last;
    logic                w_rd_last;
    logic                w_drain_done;
    logic                w_abort;

`ifdef SOBEL_FRAME_CNT_EN
    logic [15:0]         r_frame_cnt;
    assign w_abort = bus.abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_wr_en   = bus.pix_valid & r_pix_ready;
    assign w_rd_en   = bus.out_ready & (r_state == S_PROC);
    assign w_wr_last = w_wr_en
                       && (r_wr_row == WR_ROW_LAST)
                       && (r_wr_col == WR_COL_LAST);
    assign w_rd_last = w_rd_en
                       && (r_win_row == WIN_ROW_LAST)
                       && (r_win_col == WIN_COL_LAST);

    // Result-valid delay line; bit CORE_LAT-1 is the core output strobe.
    always_comb begin
        w_pipe_nxt    = r_pipe << 1;
        w_pipe_nxt[0] = w_rd_en;
    end

    // Leave DRAIN once the last result leaves the delay line this cycle,
    // so frame_done lands in the first IDLE cycle.
    assign w_drain_done = (r_state == S_DRAIN)
                          && (w_pipe_nxt == '0)
                          && !w_abort;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start)   w_state_nxt = S_LOAD;
            S_LOAD:  if (w_wr_last)   w_state_nxt = S_PROC;
            S_PROC:  if (w_rd_last)   w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pix_ready  <= 1'b0;
            r_load_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_pipe       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pix_ready  <= (w_state_nxt == S_LOAD);
            r_load_done  <= w_wr_last && !w_abort;
            r_frame_done <= w_drain_done;
            r_pipe       <= w_abort ? '0 : w_pipe_nxt;
        end
    end

    // Write address of the current LOAD beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_row <= '0;
            r_wr_col <= '0;
        end else if (w_abort) begin
            r_wr_row <= '0;
            r_wr_col <= '0;
        end else if (w_wr_en) begin
            if (r_wr_col == WR_COL_LAST) begin
                r_wr_col <= '0;
                if (r_wr_row == WR_ROW_LAST)
                    r_wr_row <= '0;
                else
                    r_wr_row <= r_wr_row + 9'd1;
            end else begin
                r_wr_col <= r_wr_col + 10'd1;
            end
        end
    end

    // Top-left corner of the next window to issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_row <= '0;
            r_win_col <= '0;
        end else if (w_abort) begin
            r_win_row <= '0;
            r_win_col <= '0;
        end else if (w_rd_en) begin
            if (r_win_col == WIN_COL_LAST) begin
                r_win_col <= '0;
                if (r_win_row == WIN_ROW_LAST)
                    r_win_row <= '0;
                else
                    r_win_row <= r_win_row + 9'd1;
            end else begin
                r_win_col <= r_win_col + 10'd1;
            end
        end
    end

`ifdef SOBEL_FRAME_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_frame_cnt <= '0;
        else if (w_drain_done)
            r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign bus.frame_cnt = r_frame_cnt;
`endif

    assign bus.pix_ready  = r_pix_ready;
    assign bus.wr_en      = w_wr_en;
    assign bus.wr_row     = r_wr_row;
    assign bus.wr_col     = r_wr_col;
    assign bus.rd_en      = w_rd_en;
    assign bus.win_row    = r_win_row;
    assign bus.win_col    = r_win_col;
    assign bus.out_valid  = r_pipe[CORE_LAT-1];
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.load_done  = r_load_done;
    assign bus.frame_done = r_frame_done;

endmodule
